// File: rtl/config_nios2_gen2_0_cpu_debug_scan_master.sv
`default_nettype none
// ============================================================================
// Module   : config_nios2_gen2_0_cpu_debug_scan_master
// Brief    : Drives a virtual-JTAG debug slave. A command with a 2-bit virtual
//            IR and up to SR_WIDTH data bits becomes one UIR/CDR/SDR.../UDR/RTI
//            sequence on a divided tck. The tdo bits and the slave's IR
//            return are handed back as a single response.
// Revision : 1.0 - initial release
// ============================================================================
module config_nios2_gen2_0_cpu_debug_scan_master #(
  parameter int TCK_DIV  = 2,
  parameter int SR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [5:0]          cmd_len,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [1:0]          rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo,
  input  logic [1:0]          vji_ir_out
);

  // Slot timing: a slot is 2*TCK_DIV clk cycles, tck low for the first half.
  localparam logic [8:0] c_half   = 9'(TCK_DIV);
  localparam logic [8:0] c_last   = 9'(2 * TCK_DIV - 1);
  localparam logic [5:0] c_sr_len = 6'(SR_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [8:0]          div_cnt;
  logic [5:0]          bit_cnt;
  logic [5:0]          len_q;
  logic [SR_WIDTH-1:0] data_q;
  logic [1:0]          ir_q;
  logic [SR_WIDTH-1:0] cap_q;
  logic [1:0]          rsp_ir_q;
  logic [5:0]          eff_len;
  logic                slot_end;
  logic                sample;
  logic                active;
  logic                accept;

  assign slot_end = (div_cnt == c_last);
  assign sample   = (div_cnt == c_half);
  assign active   = (state == ST_UIR) || (state == ST_CDR) || (state == ST_SDR) ||
                    (state == ST_UDR) || (state == ST_RTI);
  assign accept   = cmd_valid && cmd_ready;

  // Zero and oversize lengths both mean a full-width scan.
  always_comb begin
    eff_len = cmd_len;
    if ((cmd_len == 6'd0) || (cmd_len > c_sr_len)) begin
      eff_len = c_sr_len;
    end
  end

  // State register; only moves at slot boundaries while scanning.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state sequencing and state-decoded JTAG strobes.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    vji_uir   = 1'b0;
    vji_cdr   = 1'b0;
    vji_sdr   = 1'b0;
    vji_udr   = 1'b0;
    vji_rti   = 1'b0;
    vji_tdi   = 1'b0;
    vji_tck   = active && (div_cnt >= c_half);
    case (state)
      ST_IDLE: begin
        vji_rti   = 1'b1;
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_UIR;
      end
      ST_UIR: begin
        vji_uir = 1'b1;
        if (slot_end) state_nxt = ST_CDR;
      end
      ST_CDR: begin
        vji_cdr = 1'b1;
        if (slot_end) state_nxt = ST_SDR;
      end
      ST_SDR: begin
        vji_sdr = 1'b1;
        vji_tdi = data_q[bit_cnt];
        if (slot_end && (bit_cnt == (len_q - 6'd1))) state_nxt = ST_UDR;
      end
      ST_UDR: begin
        vji_udr = 1'b1;
        if (slot_end) state_nxt = ST_RTI;
      end
      ST_RTI: begin
        vji_rti = 1'b1;
        if (slot_end) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, slot/bit counters and tdo / IR capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      len_q    <= '0;
      data_q   <= '0;
      ir_q     <= '0;
      cap_q    <= '0;
      rsp_ir_q <= '0;
    end else if (accept) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      len_q    <= eff_len;
      data_q   <= cmd_data;
      ir_q     <= cmd_ir;
      cap_q    <= '0;
    end else if (active) begin
      div_cnt <= slot_end ? 9'd0 : (div_cnt + 9'd1);
      if (sample && (state == ST_UIR)) rsp_ir_q <= vji_ir_out;
      if (sample && (state == ST_SDR)) cap_q[bit_cnt] <= vji_tdo;
      if (slot_end && (state == ST_SDR)) bit_cnt <= bit_cnt + 6'd1;
    end
  end

  assign rsp_data  = cap_q;
  assign rsp_ir    = rsp_ir_q;
  assign vji_ir_in = ir_q;

endmodule
`default_nettype wire
